// File: rtl/pipe_pkg.sv
// Shared decode/execute definitions: register address width,
// default datapath widths and control-bundle field offsets.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN_DEF   = 64;
  localparam int CTRL_W_DEF = 16;

  localparam int CTRL_REGWR_BIT    = 0;
  localparam int CTRL_MEMTOREG_BIT = 1;
  localparam int CTRL_ALUOP_LSB    = 2;
  localparam int CTRL_ALUOP_W      = 4;
  localparam int CTRL_MEMWR_BIT    = 6;
  localparam int CTRL_SIZE_LSB     = 7;
  localparam int CTRL_SIZE_W       = 2;

  // Packed entry: {ctrl, memRead, rd, imm, rdata1, rdata2, pc, pcplus4}
  function automatic int entryWidth(int xlen, int ctrlW);
    return ctrlW + 1 + REG_ADDR_W + 5 * xlen;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload register with valid flag, load enable and clear.
// Clear wins over load; payload is kept when only the valid drops.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_buffer.sv
// ID/EX boundary buffer: valid/ready handshake, optional skid entry,
// load-use hazard stall with bubble counting, and flush on redirect.
module id_ex_pipe_buffer
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  in_mem_read,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_uses_rs1,
  input  logic                  in_uses_rs2,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [XLEN-1:0]       in_rdata1,
  input  logic [XLEN-1:0]       in_rdata2,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_pcplus4,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic                  out_mem_read,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic [XLEN-1:0]       out_rdata1,
  output logic [XLEN-1:0]       out_rdata2,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_pcplus4,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam int W      = entryWidth(XLEN, CTRL_W);
  localparam int RD_LSB = 5 * XLEN;
  localparam int MR_POS = RD_LSB + REG_ADDR_W;

  logic [W-1:0] inBus;
  logic [W-1:0] mainQ;
  logic [W-1:0] skidQ;
  logic         mainValid;
  logic         skidValid;
  logic         xfer;
  logic         mainFree;
  logic         mainLoad;
  logic         mainClr;

  logic [CTRL_W-1:0] ctrlRaw;
  logic              memReadRaw;

  logic                  refValid;
  logic                  refMemRead;
  logic [REG_ADDR_W-1:0] refRd;
  logic                  hit1;
  logic                  hit2;
  logic                  bump;

  assign inBus = {in_ctrl, in_mem_read, in_rd, in_imm,
                  in_rdata1, in_rdata2, in_pc, in_pcplus4};

  assign xfer     = in_valid & in_ready;
  assign mainFree = !mainValid | out_ready;

  // Main refills from skid first so ordering is preserved
  assign mainLoad = !flush & mainFree & (skidValid | xfer);
  assign mainClr  = flush | (mainFree & !skidValid & !xfer);

  pipe_entry #(.W(W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (mainLoad),
    .clr   (mainClr),
    .d     (skidValid ? skidQ : inBus),
    .valid (mainValid),
    .q     (mainQ)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skidLoad;
      logic skidClr;

      assign skidLoad = xfer & (!mainFree | skidValid);
      assign skidClr  = flush | (mainFree & skidValid & !xfer);

      pipe_entry #(.W(W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skidLoad),
        .clr   (skidClr),
        .d     (inBus),
        .valid (skidValid),
        .q     (skidQ)
      );

      assign in_ready = !skidValid & !load_use_stall & !flush;
    end else begin : g_noskid
      assign skidValid = 1'b0;
      assign skidQ     = '0;
      assign in_ready  = mainFree & !load_use_stall & !flush;
    end
  endgenerate

  // The youngest held bundle is the one a new instruction depends on
  assign refValid   = skidValid | mainValid;
  assign refMemRead = skidValid ? skidQ[MR_POS] : mainQ[MR_POS];
  assign refRd      = skidValid ? skidQ[RD_LSB +: REG_ADDR_W]
                                : mainQ[RD_LSB +: REG_ADDR_W];

  assign hit1 = in_uses_rs1 & (in_rs1 == refRd);
  assign hit2 = in_uses_rs2 & (in_rs2 == refRd);

  assign load_use_stall = in_valid & refValid & refMemRead
                        & (refRd != '0) & (hit1 | hit2);

  assign {ctrlRaw, memReadRaw, out_rd, out_imm,
          out_rdata1, out_rdata2, out_pc, out_pcplus4} = mainQ;

  assign out_valid    = mainValid;
  assign out_ctrl     = mainValid ? ctrlRaw : '0;
  assign out_mem_read = mainValid & memReadRaw;

  assign bump = out_ready & load_use_stall & !flush
              & mainFree & !skidValid & !xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (bump && (bubble_count != '1)) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_buffer.sv
// Directed bench for id_ex_pipe_buffer (SKID=1, CNT_W=4 so the
// bubble counter saturation can be reached quickly).
module tb_id_ex_pipe_buffer;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_mem_read;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic              in_uses_rs1, in_uses_rs2;
  logic [XLEN-1:0]   in_imm, in_rdata1, in_rdata2, in_pc, in_pcplus4;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_mem_read;
  logic [4:0]        out_rd;
  logic [XLEN-1:0]   out_imm, out_rdata1, out_rdata2, out_pc, out_pcplus4;
  logic              load_use_stall;
  logic [CNT_W-1:0]  bubble_count;

  int nChk = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  id_ex_pipe_buffer #(
    .XLEN(XLEN), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_mem_read(in_mem_read),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_imm(in_imm), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
    .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_mem_read(out_mem_read),
    .out_rd(out_rd), .out_imm(out_imm),
    .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4),
    .load_use_stall(load_use_stall),
    .bubble_count(bubble_count)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic ld,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [15:0] ctrl);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_pcplus4  = pc + 64'd4;
    in_mem_read = ld;
    in_rd       = rd;
    in_rs1      = rs1;
    in_uses_rs1 = u1;
    in_ctrl     = ctrl;
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_mem_read = 1'b0;
    in_uses_rs1 = 1'b0;
    #1;
  endtask

  // Load then dependent instruction: exactly one bubble per call
  task automatic hazardRound();
    out_ready = 1'b0;
    offer(64'h200, 1'b1, 5'd7, 5'd0, 1'b0, 16'h3);
    tick();
    offer(64'h204, 1'b0, 5'd8, 5'd7, 1'b1, 16'h1);
    out_ready = 1'b1;
    tick();
    tick();
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_ctrl = '0;
    in_mem_read = 1'b0;
    in_rd = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_uses_rs1 = 1'b0;
    in_uses_rs2 = 1'b0;
    in_imm = '0;
    in_rdata1 = '0;
    in_rdata2 = '0;
    in_pc = '0;
    in_pcplus4 = '0;
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;

    // Asynchronous reset while holding a valid bundle
    in_rdata1 = 64'hDEAD;
    offer(64'h100, 1'b0, 5'd1, 5'd0, 1'b0, 16'hABCD);
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_rdata1", out_rdata1, 64'hDEAD);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ctrl", 64'(out_ctrl), 64'd0);
    check("arst_bubbles", 64'(bubble_count), 64'd0);
    check("arst_rdata1", out_rdata1, 64'd0);
    rst = 1'b0;
    in_rdata1 = '0;
    idle();

    // Streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(64'(4 * i), 1'b0, 5'd2, 5'd0, 1'b0, 16'h5);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_pc", out_pc, 64'(4 * i));
    end
    idle();
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Back-pressure fills main then skid
    out_ready = 1'b0;
    offer(64'h0, 1'b0, 5'd3, 5'd0, 1'b0, 16'h7);
    check("bp_rdy0", 64'(in_ready), 64'd1);
    tick();
    offer(64'h4, 1'b0, 5'd3, 5'd0, 1'b0, 16'h7);
    check("bp_rdy1", 64'(in_ready), 64'd1);
    tick();
    offer(64'h8, 1'b0, 5'd3, 5'd0, 1'b0, 16'h7);
    check("bp_rdy2", 64'(in_ready), 64'd0);
    tick();
    check("bp_hold_pc", out_pc, 64'h0);
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", 64'(in_ready), 64'd0);
    tick();
    check("bp_order1", out_pc, 64'h4);
    check("bp_rel_rdy2", 64'(in_ready), 64'd1);
    tick();
    check("bp_order2", out_pc, 64'h8);
    idle();
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Load-use hazard on x5
    out_ready = 1'b0;
    offer(64'h20, 1'b1, 5'd5, 5'd0, 1'b0, 16'h3);
    tick();
    check("lu_load_mr", 64'(out_mem_read), 64'd1);
    offer(64'h24, 1'b0, 5'd6, 5'd5, 1'b1, 16'h1);
    check("lu_stall", 64'(load_use_stall), 64'd1);
    check("lu_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("lu_bubble_valid", 64'(out_valid), 64'd0);
    check("lu_bubble_ctrl", 64'(out_ctrl), 64'd0);
    check("lu_bubble_mr", 64'(out_mem_read), 64'd0);
    check("lu_stall_clear", 64'(load_use_stall), 64'd0);
    check("lu_count", 64'(bubble_count), 64'd1);
    tick();
    check("lu_dep_valid", 64'(out_valid), 64'd1);
    check("lu_dep_pc", out_pc, 64'h24);
    idle();
    tick();

    // Same pattern through x0 never stalls
    out_ready = 1'b0;
    offer(64'h30, 1'b1, 5'd0, 5'd0, 1'b0, 16'h3);
    tick();
    offer(64'h34, 1'b0, 5'd6, 5'd0, 1'b1, 16'h1);
    check("x0_stall", 64'(load_use_stall), 64'd0);
    check("x0_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("x0_dep_pc", out_pc, 64'h34);
    check("x0_count", 64'(bubble_count), 64'd1);
    idle();
    tick();

    // Flush with main and skid full plus a new offer
    out_ready = 1'b0;
    offer(64'h40, 1'b0, 5'd1, 5'd0, 1'b0, 16'h9);
    tick();
    offer(64'h44, 1'b0, 5'd1, 5'd0, 1'b0, 16'h9);
    tick();
    offer(64'h48, 1'b0, 5'd1, 5'd0, 1'b0, 16'h9);
    flush = 1'b1;
    #1;
    check("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    idle();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ctrl", 64'(out_ctrl), 64'd0);
    out_ready = 1'b1;
    tick();
    check("fl_no_accept", 64'(out_valid), 64'd0);
    check("fl_count", 64'(bubble_count), 64'd1);

    // Saturation of the 4-bit bubble counter
    for (int i = 0; i < 14; i++) hazardRound();
    check("sat_reach", 64'(bubble_count), 64'd15);
    for (int i = 0; i < 2; i++) hazardRound();
    check("sat_hold", 64'(bubble_count), 64'd15);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_pipe_buffer.md
Name: id_ex_pipe_buffer

Overview:
- Parametrised decode-to-execute boundary register that replaces the fixed single-register ID/EX latch.
- Carries the decoded bundle: control, register addresses, immediate, operands and PCs.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, load-use hazard detection with bubble insertion, and flush on redirect.
- Sits between the decode stage outputs and the execute stage inputs.

Parameters:
- XLEN, 64, datapath width of operands, immediate and PCs.
- CTRL_W, 16, width of the opaque packed control bundle (RegWriteEn, MemtoReg, ALUOp, sizes, ...).
- SKID, 1, 0 = single entry; 1 = main entry plus one skid entry, so in_ready has no combinational path from out_ready.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  decode presents a bundle.
- in_ready  out  1  buffer accepts the bundle this cycle.
- in_ctrl  in  CTRL_W  packed control.
- in_mem_read  in  1  bundle is a load.
- in_rd, in_rs1, in_rs2  in  5 each  register addresses.
- in_uses_rs1, in_uses_rs2  in  1 each  the instruction reads that source.
- in_imm, in_rdata1, in_rdata2, in_pc, in_pcplus4  in  XLEN each  payload.
- flush  in  1  redirect from branch/jump resolution; kill everything held and incoming.
- out_valid  out  1  execute bundle valid.
- out_ready  in  1  execute consumes the bundle this cycle.
- out_ctrl, out_mem_read, out_rd, out_imm, out_rdata1, out_rdata2, out_pc, out_pcplus4  out  widths as inputs  head entry.
- load_use_stall  out  1  hazard is holding decode this cycle.
- bubble_count  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (async, immediate): both entries invalid, all payload registers 0, out_valid=0, bubble_count=0.
- Gating: out_ctrl and out_mem_read are forced to 0 whenever out_valid=0, so a bubble never writes the register file or memory.
- Accept: a transfer occurs when in_valid & in_ready. The accepted bundle appears at out_* on the next cycle (1-cycle latency) if the main entry is free or being consumed.
- in_ready, SKID=0: (!out_valid | out_ready) & !load_use_stall & !flush.
- in_ready, SKID=1: !skid_valid & !load_use_stall & !flush. It is registered-state-only apart from the hazard and flush terms.
- Skid fill: when main is valid, out_ready=0 and a transfer occurs, the bundle goes to skid.
- Skid drain: when main is consumed and skid is valid, skid moves to main on the same edge. A simultaneous new transfer then goes to skid; order is always preserved.
- Hazard: ref = skid entry if skid_valid, else main entry. load_use_stall = in_valid & ref_valid & ref.mem_read & (ref.rd != 0) & ((in_uses_rs1 & in_rs1 == ref.rd) | (in_uses_rs2 & in_rs2 == ref.rd)).
- Hazard resolution: while stalled, the incoming bundle is not accepted. If main is consumed and nothing refills it, out_valid=0 next cycle (a bubble). The stall clears once the load has left the buffer.
- Bubble counter: increments by 1 on each edge where out_ready=1, main becomes empty and load_use_stall=1. It saturates at all-ones.
- Flush: on the next edge both entries are invalidated; in_ready=0 during the flush cycle. Flush overrides any simultaneous accept, drain or hazard. bubble_count is unaffected.
- Register x0: rd=0 never creates a hazard.
- Mid-operation reset: drops all entries asynchronously. There is no partial-state recovery.

Decomposition:
- Shared package pipe_pkg: REG_ADDR_W=5, default XLEN, CTRL_W, and the control-bundle field offsets shared with decode and execute.
- One natural sub-module: pipe_entry, a payload register with valid, load enable and clear. It is instantiated for main and, under generate when SKID=1, for skid.
- Hazard compare and counter stay in the top level.

Test Plan:
- Reset while valid with in_rdata1=0xDEAD -> out_valid=0, out_ctrl=0, bubble_count=0 immediately; no clock edge is needed.
- Streaming, out_ready=1, 4 back-to-back bundles pc=0x0,0x4,0x8,0xC -> out_pc equals the same sequence one cycle later; in_ready stays 1.
- SKID=1, out_ready=0 for 2 cycles with 3 bundles offered -> 2 accepted, in_ready=0 on the 3rd. Release -> order 0x0,0x4, then 0x8.
- Load rd=5 held, next bundle uses_rs1 with rs1=5 -> load_use_stall=1; after the load is consumed, one bubble (out_valid=0, out_ctrl=0), then the dependent bundle; bubble_count=1. The same stimulus with rd=0 -> no stall.
- flush asserted with main and skid valid plus a new in_valid -> next cycle out_valid=0; the incoming bundle is not accepted.
- Force bubble_count to saturate at CNT_W=4 -> holds at 15.
